// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, PS/2 mouse command/response codes and frame parity helper.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, TX_SETUP, TX_LOW, TX_HIGH, RX_WAIT, RX_LOW, RX_HIGH, RX_ACK} state_t;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DISABLE  = 8'hF5;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_dev_clkgen.sv
// ps2_dev_clkgen: PS/2 half-period timer; tick marks the last cycle of each half, restart holds it at phase start.
module ps2_dev_clkgen #(parameter int HALF_CLK = 2000) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(HALF_CLK + 1);
    logic [W-1:0] cnt;
    assign tick = !restart && cnt == W'(HALF_CLK - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ps2_mouse_dev.sv
// ps2_mouse_dev: PS/2 mouse device side; receives host commands, answers them and streams movement reports.
module ps2_mouse_dev import ps2_pkg::*; #(
    parameter int HALF_CLK    = 2000,
    parameter int IDLE_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2c,
    inout  wire        ps2d,
    input  logic       rpt_valid,
    output logic       rpt_ready,
    input  logic [2:0] rpt_btn,
    input  logic [8:0] rpt_dx,
    input  logic [8:0] rpt_dy,
    output logic       reporting,
    output logic [7:0] rx_cmd,
    output logic       rx_cmd_tick,
    output logic       busy
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    state_t state, state_n;
    logic [1:0] c_sy, d_sy;
    logic [2:0] c_h, d_h;
    logic c_s, d_s, c_oe, d_oe, tick, line_idle, inhibit, host_req, rx_fin, tx_pop, par_ok, ferr, ack_ph;
    logic [7:0] q [3];
    logic [1:0] qn;
    logic [3:0] idx;
    logic [8:0] rx_sh;
    logic [10:0] frame;
    logic [IW-1:0] idle_cnt;

    assign ps2c = c_oe ? 1'b0 : 1'bz;
    assign ps2d = d_oe ? 1'b0 : 1'bz;
    assign c_s = c_sy[1];
    assign d_s = d_sy[1];
    assign line_idle = idle_cnt == IW'(IDLE_CYCLES);
    // Synchronized lines lag our own drive; ignore a low we released in the last few cycles.
    assign inhibit = !c_s && !(|c_h);
    assign host_req = !d_s && c_s && !(|d_h);
    assign frame = {1'b1, odd_par(q[0]), q[0], 1'b0};
    assign par_ok = ^rx_sh;
    assign tx_pop = state == TX_LOW && tick && idx == 4'd10;
    assign rx_fin = tick && ((state == RX_ACK && ack_ph) || (state == RX_HIGH && idx == 4'd9 && d_s && ferr));
    assign rpt_ready = reporting && state == IDLE && qn == 2'd0 && rpt_valid;
    assign busy = state != IDLE || qn != 2'd0;

    ps2_dev_clkgen #(.HALF_CLK(HALF_CLK)) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .tick    (tick)
    );

    always_comb begin
        state_n = state;
        c_oe = 1'b0;
        d_oe = 1'b0;
        case (state)
            IDLE:              state_n = host_req ? RX_WAIT : (qn != 2'd0 && line_idle) ? TX_SETUP : IDLE;
            TX_SETUP, TX_HIGH: begin
                d_oe = !frame[idx];
                state_n = inhibit ? IDLE : tick ? TX_LOW : state;
            end
            TX_LOW: begin
                c_oe = 1'b1;
                d_oe = !frame[idx];
                if (tick) state_n = idx == 4'd10 ? IDLE : TX_HIGH;
            end
            RX_WAIT: if (tick) state_n = RX_LOW;
            RX_LOW: begin
                c_oe = 1'b1;
                if (tick) state_n = RX_HIGH;
            end
            RX_HIGH: if (tick) state_n = (idx != 4'd9 || !d_s) ? RX_LOW : ferr ? IDLE : RX_ACK;
            RX_ACK: begin
                c_oe = !ack_ph;
                d_oe = 1'b1;
                if (tick && ack_ph) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            c_sy <= 2'b11;
            d_sy <= 2'b11;
            c_h <= '0;
            d_h <= '0;
            q <= '{default: '0};
            qn <= '0;
            idx <= '0;
            rx_sh <= '0;
            ferr <= 1'b0;
            ack_ph <= 1'b0;
            idle_cnt <= '0;
            reporting <= 1'b0;
            rx_cmd <= '0;
            rx_cmd_tick <= 1'b0;
        end else begin
            state <= state_n;
            c_sy <= {c_sy[0], ps2c};
            d_sy <= {d_sy[0], ps2d};
            c_h <= {c_h[1:0], c_oe};
            d_h <= {d_h[1:0], d_oe};
            idle_cnt <= (state != IDLE || !c_s || !d_s) ? '0 : line_idle ? idle_cnt : idle_cnt + 1'b1;
            rx_cmd_tick <= 1'b0;
            if (state == IDLE) begin
                idx <= '0;
                ferr <= 1'b0;
                ack_ph <= 1'b0;
            end
            if (tick && state == TX_LOW) idx <= idx + 1'b1;
            if (tick && state == RX_HIGH && idx != 4'd9) begin
                rx_sh <= {d_s, rx_sh[8:1]};
                idx <= idx + 1'b1;
            end
            // A low stop bit keeps the clock running until the host lets data go high.
            if (tick && state == RX_HIGH && idx == 4'd9 && !d_s) ferr <= 1'b1;
            if (tick && state == RX_ACK) ack_ph <= 1'b1;
            if (tx_pop) begin
                q[0] <= q[1];
                q[1] <= q[2];
                qn <= qn - 1'b1;
            end
            if (rpt_ready) begin
                q <= '{{2'b00, rpt_dy[8], rpt_dx[8], 1'b1, rpt_btn}, rpt_dx[7:0], rpt_dy[7:0]};
                qn <= 2'd3;
            end
            if (rx_fin) begin
                q <= '{RSP_RESEND, 8'h00, 8'h00};
                qn <= 2'd1;
                if (!ferr && par_ok) begin
                    rx_cmd <= rx_sh[7:0];
                    rx_cmd_tick <= 1'b1;
                    case (rx_sh[7:0])
                        CMD_RESET: begin
                            q <= '{RSP_ACK, RSP_BAT_OK, 8'h00};
                            qn <= 2'd3;
                            reporting <= 1'b0;
                        end
                        CMD_ENABLE: begin
                            q[0] <= RSP_ACK;
                            reporting <= 1'b1;
                        end
                        CMD_DISABLE, CMD_DEFAULTS: begin
                            q[0] <= RSP_ACK;
                            reporting <= 1'b0;
                        end
                        CMD_GET_ID: begin
                            q[0] <= RSP_ACK;
                            qn <= 2'd2;
                        end
                        default: ;
                    endcase
                end
            end
        end
endmodule

// File: tb/tb_ps2_mouse_dev.sv
// tb_ps2_mouse_dev: host-side model driving command vectors and checking device responses and reports.
module tb_ps2_mouse_dev;
    localparam int HALF = 8;
    localparam int IDLE = 20;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic h_c = 1'b0;
    logic h_d = 1'b0;
    logic rpt_valid = 1'b0;
    logic [2:0] rpt_btn = '0;
    logic [8:0] rpt_dx = '0;
    logic [8:0] rpt_dy = '0;
    logic rpt_ready, reporting, rx_cmd_tick, busy;
    logic [7:0] rx_cmd;
    wire ps2c, ps2d;
    int checks = 0;
    int fails = 0;
    int tick_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = h_c ? 1'b0 : 1'bz;
    assign ps2d = h_d ? 1'b0 : 1'bz;

    ps2_mouse_dev #(.HALF_CLK(HALF), .IDLE_CYCLES(IDLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_btn     (rpt_btn),
        .rpt_dx      (rpt_dx),
        .rpt_dy      (rpt_dy),
        .reporting   (reporting),
        .rx_cmd      (rx_cmd),
        .rx_cmd_tick (rx_cmd_tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rx_cmd_tick === 1'b1) tick_cnt <= tick_cnt + 1;

    typedef struct {
        logic [7:0]  cmd;
        bit          bad_par;
        bit          bad_stop;
        bit          ack;
        int          ticks;
        logic [7:0]  rx;
        bit          rep;
        int          n;
        logic [23:0] rsp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_c(input logic v, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2c !== v && n < 5000);
        if (ps2c !== v) chk("timeout_ps2c", 32'(ps2c), 32'(v));
    endtask

    task automatic host_send(input logic [7:0] b, input bit bad_par, input bit bad_stop, output bit ack);
        logic [9:0] bits;
        int n;
        bits = {1'b1, (~^b) ^ bad_par, b};
        h_c = 1'b1;
        repeat (10) @(negedge clk);
        h_d = 1'b1;
        repeat (2) @(negedge clk);
        h_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_c(1'b0, n);
            h_d = (i == 9 && bad_stop) ? 1'b1 : !bits[i];
            wait_c(1'b1, n);
        end
        wait_c(1'b0, n);
        h_d = 1'b0;
        repeat (3) @(negedge clk);
        ack = ps2d === 1'b0;
        wait_c(1'b1, n);
    endtask

    task automatic host_recv(output logic [7:0] b, output bit fok, output int first_wait);
        logic [10:0] f;
        int n;
        for (int i = 0; i < 11; i++) begin
            wait_c(1'b0, n);
            if (i == 0) first_wait = n;
            f[i] = ps2d;
            wait_c(1'b1, n);
        end
        b = f[8:1];
        fok = f[0] == 1'b0 && f[10] == 1'b1 && f[9] == ~^f[8:1];
    endtask

    initial begin
        vec_t tv [9];
        logic [7:0] b;
        bit fok, ack, lowseen;
        int w, t0;
        tv[0] = '{8'hFF, 0, 0, 1, 1, 8'hFF, 0, 3, 24'hFAAA00};
        tv[1] = '{8'hF4, 0, 0, 1, 1, 8'hF4, 1, 1, 24'hFA0000};
        tv[2] = '{8'hF2, 0, 0, 1, 1, 8'hF2, 1, 2, 24'hFA0000};
        tv[3] = '{8'hF6, 0, 0, 1, 1, 8'hF6, 0, 1, 24'hFA0000};
        tv[4] = '{8'hF4, 0, 0, 1, 1, 8'hF4, 1, 1, 24'hFA0000};
        tv[5] = '{8'hF5, 0, 0, 1, 1, 8'hF5, 0, 1, 24'hFA0000};
        tv[6] = '{8'h4F, 1, 0, 1, 0, 8'hF5, 0, 1, 24'hFE0000};
        tv[7] = '{8'h12, 0, 0, 1, 1, 8'h12, 0, 1, 24'hFE0000};
        tv[8] = '{8'hF4, 0, 1, 0, 0, 8'h12, 0, 1, 24'hFE0000};

        repeat (3) @(negedge clk);
        chk("rst_ps2c", 32'(ps2c), 1);
        chk("rst_ps2d", 32'(ps2d), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_reporting", 32'(reporting), 0);
        chk("rst_rx_cmd", 32'(rx_cmd), 0);
        chk("rst_tick", 32'(rx_cmd_tick), 0);
        chk("rst_rpt_ready", 32'(rpt_ready), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            t0 = tick_cnt;
            host_send(tv[i].cmd, tv[i].bad_par, tv[i].bad_stop, ack);
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tv[i].ack));
            for (int k = 0; k < tv[i].n; k++) begin
                host_recv(b, fok, w);
                chk($sformatf("v%0d_rsp%0d", i, k), 32'(b), 32'(tv[i].rsp[23-8*k -: 8]));
                chk($sformatf("v%0d_frame%0d", i, k), 32'(fok), 1);
            end
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_ticks", i), 32'(tick_cnt - t0), 32'(tv[i].ticks));
            chk($sformatf("v%0d_rx_cmd", i), 32'(rx_cmd), 32'(tv[i].rx));
            chk($sformatf("v%0d_reporting", i), 32'(reporting), 32'(tv[i].rep));
            chk($sformatf("v%0d_busy", i), 32'(busy), 0);
        end

        host_send(8'hF4, 0, 0, ack);
        host_recv(b, fok, w);
        chk("rpt_en_ack", 32'(b), 32'hFA);
        repeat (2) @(negedge clk);
        rpt_btn = 3'b001;
        rpt_dx = 9'h1FD;
        rpt_dy = 9'h005;
        rpt_valid = 1'b1;
        #1;
        chk("rpt_ready_hi", 32'(rpt_ready), 1);
        @(negedge clk);
        chk("rpt_ready_once", 32'(rpt_ready), 0);
        chk("rpt_busy", 32'(busy), 1);
        rpt_valid = 1'b0;
        host_recv(b, fok, w);
        chk("rpt_b0", 32'(b), 32'h19);
        host_recv(b, fok, w);
        chk("rpt_b1", 32'(b), 32'hFD);
        host_recv(b, fok, w);
        chk("rpt_b2", 32'(b), 32'h05);
        chk("rpt_frame", 32'(fok), 1);

        repeat (2) @(negedge clk);
        rpt_btn = 3'b010;
        rpt_dx = 9'h001;
        rpt_dy = 9'h1FF;
        rpt_valid = 1'b1;
        #1;
        chk("flush_rpt_ready", 32'(rpt_ready), 1);
        @(negedge clk);
        rpt_valid = 1'b0;
        host_send(8'hF5, 0, 0, ack);
        chk("flush_ack", 32'(ack), 1);
        host_recv(b, fok, w);
        chk("flush_rsp", 32'(b), 32'hFA);
        lowseen = 1'b0;
        repeat (IDLE + 4 * HALF) begin
            @(negedge clk);
            if (ps2c !== 1'b1) lowseen = 1'b1;
        end
        chk("flush_no_more_tx", 32'(lowseen), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_reporting", 32'(reporting), 0);

        host_send(8'hF5, 0, 0, ack);
        for (int k = 0; k < 4; k++) begin
            wait_c(1'b0, w);
            wait_c(1'b1, w);
        end
        h_c = 1'b1;
        repeat (30) @(negedge clk);
        chk("inh_ps2d_released", 32'(ps2d), 1);
        chk("inh_busy", 32'(busy), 1);
        h_c = 1'b0;
        host_recv(b, fok, w);
        chk("inh_resend", 32'(b), 32'hFA);
        chk("inh_frame", 32'(fok), 1);
        chk("inh_gap", 32'(w >= IDLE + HALF && w <= IDLE + HALF + 8), 1);

        h_c = 1'b1;
        repeat (10) @(negedge clk);
        h_d = 1'b1;
        repeat (2) @(negedge clk);
        h_c = 1'b0;
        wait_c(1'b0, w);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_ps2c", 32'(ps2c), 1);
        h_d = 1'b0;
        #1;
        chk("mrst_ps2d", 32'(ps2d), 1);
        chk("mrst_rx_cmd", 32'(rx_cmd), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_tick", 32'(rx_cmd_tick), 0);
        lowseen = 1'b0;
        repeat (3 * HALF) begin
            @(negedge clk);
            if (ps2c !== 1'b1) lowseen = 1'b1;
        end
        chk("mrst_no_clock", 32'(lowseen), 0);
        rst = 1'b1;
        repeat (3 * HALF) begin
            @(negedge clk);
            if (ps2c !== 1'b1) lowseen = 1'b1;
        end
        chk("mrst_quiet", 32'(lowseen), 0);
        chk("mrst_busy_after", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_dev.md
PS2_MOUSE_DEV -- requirements
Module: ps2_mouse_dev

Interface
REQ-001 Parameter HALF_CLK, default 2000, meaning clk cycles per PS/2 clock half-period (40 us at 50 MHz).
REQ-002 Parameter IDLE_CYCLES, default 2500, meaning clk cycles both lines must read high before a transmission may start (50 us).
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ps2c  inout  1  PS/2 clock, open-drain: module drives 0 or releases to z.
REQ-006 ps2d  inout  1  PS/2 data, open-drain: module drives 0 or releases to z.
REQ-007 rpt_valid  input  1  movement report offered.
REQ-008 rpt_ready  output  1  report accepted this cycle (valid and ready).
REQ-009 rpt_btn  input  3  {middle, right, left}.
REQ-010 rpt_dx, rpt_dy  input  9 each  two's-complement movement.
REQ-011 reporting  output  1  data reporting enabled.
REQ-012 rx_cmd  output  8  last valid host byte; rx_cmd_tick  output  1  one-cycle pulse on valid host byte.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE or a response is pending.

Function
REQ-014 ps2c/ps2d inputs pass a 2-flop synchronizer; all decisions use synchronized values.
REQ-015 Frame: start 0, 8 data LSB first, odd parity, stop 1; one PS/2 clock = HALF_CLK high then HALF_CLK low.
REQ-016 FSM states: IDLE, TX_SETUP, TX_LOW, TX_HIGH, RX_WAIT, RX_LOW, RX_HIGH, RX_ACK.
REQ-017 IDLE -> TX_SETUP when a byte is pending and both lines have read high for IDLE_CYCLES consecutive cycles.
REQ-018 TX: data bit driven at start of each high half; clock driven low for HALF_CLK; 11 clocks; lines released after stop; byte popped from pending queue only on completion.
REQ-019 TX inhibit: synchronized ps2c low while module is not driving it, before 11th falling edge -> release both lines, return to IDLE, byte stays pending and is resent whole.
REQ-020 Host request: in IDLE (or TX aborted), ps2d low with ps2c released -> RX_WAIT; after HALF_CLK, generate 11 clocks, sample ps2d at end of each high half (8 data, parity, stop).
REQ-021 RX_ACK: stop sampled 1 -> drive ps2d low for one full PS/2 clock, then release; stop sampled 0 -> no ack, keep clocking until ps2d reads 1, then respond FE.
REQ-022 Parity error -> ack, then respond FE; rx_cmd unchanged, no tick.
REQ-023 Host byte received always flushes queued responses and any queued report packet before the new response is enqueued.
REQ-024 Command responses (queue up to 3 bytes): FF -> FA,AA,00 and reporting=0; F4 -> FA, reporting=1; F5 -> FA, reporting=0; F2 -> FA,00; F6 -> FA, reporting=0; any other -> FE.
REQ-025 rpt_ready high for one cycle only when reporting=1, FSM IDLE, queue empty, rpt_valid high.
REQ-026 Accepted report enqueues 3 bytes: {0,0,dy[8],dx[8],1,btn[2:0]}, dx[7:0], dy[7:0].
REQ-027 Simultaneous host request and pending TX start: host request wins.

Reset
REQ-028 On rst low: lines released (z), FSM IDLE, queue empty, reporting=0, rx_cmd=00, rx_cmd_tick=0, rpt_ready=0, busy=0, idle counter cleared; mid-frame reset abandons the frame with no further clock edges.

Structure
REQ-029 Package ps2_pkg holds the FSM state enum, command/response code constants (FF, F4, F5, F2, F6, FA, FE, AA) and odd-parity function.
REQ-030 One sub-module ps2_dev_clkgen: HALF_CLK counter producing phase-end pulses, restartable by the FSM.

Verification
REQ-031 Host sends FF (good parity) -> ack low one clock, rx_cmd=FF tick, device sends FA, AA, 00 with correct parity, reporting=0.
REQ-032 Host sends F4, then rpt_valid with btn=001, dx=-3, dy=+5 -> FA, then packet 19, FD, 05.
REQ-033 Host sends 0x4F with bad parity -> ack, no tick, response FE.
REQ-034 Host holds ps2c low after 4th clock of FA transmission -> lines released, FA resent whole after release plus IDLE_CYCLES.
REQ-035 Host request asserted while report packet queued -> host byte received, queue flushed, only the command response transmitted.
REQ-036 rst low mid-RX -> ps2c/ps2d release within 1 cycle, outputs at reset values.
